prog_loader: RTL
================

Name: prog_loader

Overview:
- Writer side of the processor's instruction memory.
- Accepts a byte stream, assembles 32-bit instruction words and writes them sequentially into imem from address 0.
- Holds the processor in reset while loading; releases it when the load completes.
- Sits between the bench/host byte source and the processor's imem write port and reset input.

Parameters:
ADDR_W, 10, imem word-address width
MAX_WORDS, 1024, largest legal program length in words; must be <= 2^ADDR_W
TIMEOUT, 4096, idle cycles without an accepted byte before a load aborts

Ports:
clk  input  1  system clock; all state changes on rising edge
rst  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; begins a load
in_data  input  8  stream byte
in_valid  input  1  in_data valid
in_ready  output  1  loader accepts a byte this cycle
imem_we  output  1  imem write strobe
imem_addr  output  ADDR_W  imem word address
imem_wdata  output  32  instruction word
cpu_rst  output  1  active-high reset to processor
busy  output  1  load in progress
done  output  1  last load completed successfully
error  output  1  last load aborted
words_loaded  output  ADDR_W+1  words written in current or last load

Behaviour:
- Reset (rst=0), asynchronous:
  - state=IDLE, cpu_rst=1.
  - in_ready, imem_we, busy, done, error all 0.
  - imem_addr, imem_wdata, words_loaded all 0.
- Byte transfer: a byte is accepted on a rising edge with in_valid=1 and in_ready=1. No other transfer counts.
- in_ready=1 only in LEN_LO, LEN_HI and DATA. It is 0 in IDLE, WRITE, DONE and ERR.
- Stream format:
  - 16-bit word count N, little-endian (low byte first).
  - Then N words of 4 bytes each, little-endian: first byte goes to bits[7:0], fourth byte to bits[31:24].
- States:
  - IDLE: start=1 -> LEN_LO. Clear words_loaded, imem_addr, done, error. cpu_rst stays 1.
  - LEN_LO: accepted byte -> N[7:0]; go to LEN_HI.
  - LEN_HI: accepted byte -> N[15:8]. If N==0 or N>MAX_WORDS -> ERR, else -> DATA with byte index 0.
  - DATA: each accepted byte is placed into the assembly register at lane = byte index. On the 4th byte, go to WRITE.
  - WRITE: exactly one cycle.
    - imem_we=1; imem_wdata = assembled word; imem_addr = current address.
    - Next edge: imem_addr+1 and words_loaded+1.
    - If words_loaded+1==N -> DONE, else -> DATA.
  - DONE: cpu_rst=0, done=1, busy=0. start=1 -> LEN_LO, with cpu_rst=1 reasserted on the same edge.
  - ERR: cpu_rst=1, error=1, busy=0. start=1 -> LEN_LO, clearing error.
- busy=1 in LEN_LO, LEN_HI, DATA and WRITE.
- start is ignored while busy=1.
- Write latency: the imem_we pulse is asserted in the cycle immediately after the edge that accepts the 4th byte. in_ready=0 during that cycle, so there is a one-cycle bubble per word.
- Timeout:
  - An idle counter runs in LEN_LO, LEN_HI and DATA.
  - It clears on every accepted byte and on entry to LEN_LO.
  - Reaching TIMEOUT -> ERR.
  - Words already written stay in imem. words_loaded keeps the partial count.
- Address wrap is impossible because N<=MAX_WORDS<=2^ADDR_W.
- cpu_rst changes only on edges (registered, glitch-free).
- rst asserted mid-load: immediate return to IDLE. cpu_rst=1, all else cleared. A partial load is not resumed.

Test Plan:
- Reset, then start. Stream 02 00, 13 00 00 00, 93 00 10 00 -> writes 0x00000013 at addr 0 and 0x00100093 at addr 1. done=1, cpu_rst falls 1 cycle after the second imem_we. words_loaded=2.
- Stream header 00 00 -> error=1, cpu_rst=1, no imem_we pulse.
- Header 01 04 (N=1025) with default MAX_WORDS -> ERR on the LEN_HI byte, no write.
- N=3, with in_valid toggled randomly and gaps < TIMEOUT -> 3 correct writes at addr 0..2. in_ready=0 in each WRITE cycle.
- N=4, stall after 6 data bytes for TIMEOUT cycles -> error=1, words_loaded=1, cpu_rst=1. Then start and send a valid N=1 load -> done=1.
- rst pulled low mid-DATA, and start pulsed while busy -> outputs return to reset values asynchronously; the busy-time start has no effect.

Source files
------------

// File: rtl/prog_loader.sv
// Instruction-memory loader: turns a little-endian byte stream (16-bit word count,
// then 32-bit words) into sequential imem writes, holding the CPU in reset until done.
`timescale 1ns/1ps
module prog_loader #(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024,
    parameter int TIMEOUT   = 4096
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_loaded
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  TO_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [ADDR_W:0]   WL_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LEN_LO = 3'd1,
        LEN_HI = 3'd2,
        DATA   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5,
        ERR    = 3'd6
    } state_t;

    state_t              state_r;
    logic [15:0]         len_r;
    logic [1:0]          byte_idx_r;
    logic [31:0]         word_r;
    logic [CNT_W-1:0]    idle_cnt_r;
    logic                in_ready_r;
    logic                imem_we_r;
    logic [ADDR_W-1:0]   imem_addr_r;
    logic [31:0]         imem_wdata_r;
    logic                cpu_rst_r;
    logic                busy_r;
    logic                done_r;
    logic                error_r;
    logic [ADDR_W:0]     words_loaded_r;

    logic                accept_s;
    logic                timeout_s;
    logic [15:0]         len_s;
    logic [ADDR_W:0]     wl_next_s;
    logic                last_word_s;

    function automatic logic [31:0] put_lane(input logic [31:0] word,
                                             input logic [1:0]  lane,
                                             input logic [7:0]  b);
        logic [31:0] r;
        r = word;
        case (lane)
            2'd0:    r[7:0]   = b;
            2'd1:    r[15:8]  = b;
            2'd2:    r[23:16] = b;
            default: r[31:24] = b;
        endcase
        return r;
    endfunction

    function automatic logic len_ok(input logic [15:0] n);
        return (n != 16'd0) && (32'(n) <= 32'(MAX_WORDS));
    endfunction

    assign accept_s    = in_valid & in_ready_r;
    assign timeout_s   = ~accept_s & (idle_cnt_r == TO_LAST);
    assign len_s       = {in_data, len_r[7:0]};
    assign wl_next_s   = words_loaded_r + WL_ONE;
    // Word count is compared at full width so a 16-bit N never aliases.
    assign last_word_s = (32'(wl_next_s) == 32'(len_r));

    // Loader state machine; every output is registered alongside the state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            len_r          <= 16'd0;
            byte_idx_r     <= 2'd0;
            word_r         <= 32'd0;
            idle_cnt_r     <= '0;
            in_ready_r     <= 1'b0;
            imem_we_r      <= 1'b0;
            imem_addr_r    <= '0;
            imem_wdata_r   <= 32'd0;
            cpu_rst_r      <= 1'b1;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
            error_r        <= 1'b0;
            words_loaded_r <= '0;
        end else begin
            imem_we_r <= 1'b0;
            case (state_r)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_r        <= LEN_LO;
                        idle_cnt_r     <= '0;
                        in_ready_r     <= 1'b1;
                        busy_r         <= 1'b1;
                        cpu_rst_r      <= 1'b1;
                        done_r         <= 1'b0;
                        error_r        <= 1'b0;
                        imem_addr_r    <= '0;
                        words_loaded_r <= '0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                LEN_LO: begin
                    if (accept_s) begin
                        len_r[7:0] <= in_data;
                        idle_cnt_r <= '0;
                        state_r    <= LEN_HI;
                    end else if (timeout_s) begin
                        state_r    <= ERR;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        error_r    <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + CNT_ONE;
                    end
                end
                LEN_HI: begin
                    if (accept_s) begin
                        len_r[15:8] <= in_data;
                        idle_cnt_r  <= '0;
                        if (len_ok(len_s)) begin
                            state_r    <= DATA;
                            byte_idx_r <= 2'd0;
                        end else begin
                            state_r    <= ERR;
                            in_ready_r <= 1'b0;
                            busy_r     <= 1'b0;
                            error_r    <= 1'b1;
                        end
                    end else if (timeout_s) begin
                        state_r    <= ERR;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        error_r    <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + CNT_ONE;
                    end
                end
                DATA: begin
                    if (accept_s) begin
                        idle_cnt_r <= '0;
                        word_r     <= put_lane(word_r, byte_idx_r, in_data);
                        byte_idx_r <= byte_idx_r + 2'd1;
                        if (byte_idx_r == 2'd3) begin
                            state_r      <= WRITE;
                            in_ready_r   <= 1'b0;
                            imem_we_r    <= 1'b1;
                            imem_wdata_r <= put_lane(word_r, byte_idx_r, in_data);
                        end else begin
                            state_r <= DATA;
                        end
                    end else if (timeout_s) begin
                        state_r    <= ERR;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        error_r    <= 1'b1;
                    end else begin
                        idle_cnt_r <= idle_cnt_r + CNT_ONE;
                    end
                end
                WRITE: begin
                    imem_addr_r    <= imem_addr_r + ADDR_ONE;
                    words_loaded_r <= wl_next_s;
                    if (last_word_s) begin
                        state_r    <= DONE;
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b0;
                        cpu_rst_r  <= 1'b0;
                        done_r     <= 1'b1;
                    end else begin
                        state_r    <= DATA;
                        in_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                    busy_r     <= 1'b0;
                    cpu_rst_r  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign imem_we      = imem_we_r;
    assign imem_addr    = imem_addr_r;
    assign imem_wdata   = imem_wdata_r;
    assign cpu_rst      = cpu_rst_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign error        = error_r;
    assign words_loaded = words_loaded_r;

endmodule
